// File: rtl/sr_hypot_sequencer_if.sv
// rtl/sr_hypot_sequencer_if.sv - request and shared-ALU bundle between the core and the HYPO sequencer
interface sr_hypot_sequencer_if;
  logic        start;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic [31:0] aluResult;
  logic        aluOwn;
  logic [2:0]  aluOper;
  logic [31:0] aluSrcA;
  logic [31:0] aluSrcB;
  logic        busy;
  logic        ready;
  logic [8:0]  result;

  // core side: issues the request and returns the shared ALU result
  modport master (
    output start, opA, opB, aluResult,
    input  aluOwn, aluOper, aluSrcA, aluSrcB, busy, ready, result
  );

  // sequencer side
  modport slave (
    input  start, opA, opB, aluResult,
    output aluOwn, aluOper, aluSrcA, aluSrcB, busy, ready, result
  );
endinterface

// File: rtl/sr_hypot_sequencer.sv
// rtl/sr_hypot_sequencer.sv - HYPO sequencer, floor(sqrt(a*a+b*b)) on the shared ALU; option macro HYPO_ZERO_BYPASS_EN
`ifndef ALU_ADD
`define ALU_ADD  3'b000
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 3'b011
`endif
`ifndef ALU_SUB
`define ALU_SUB  3'b100
`endif

module sr_hypot_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  sr_hypot_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SQA      = 3'd1,
    SQB      = 3'd2,
    SQRT_CMP = 3'd3,
    SQRT_SUB = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [16:0] acc;
  logic [2:0]  i;
  logic [3:0]  k;
  logic        lt;
  logic [18:0] rem;
  logic [8:0]  root;
  logic [8:0]  result_q;
  logic        own_q;
  logic        busy_q;
  logic        ready_q;

  // shift-and-add partial product: the multiplicand is a during SQA, b during SQB
  logic [7:0]  mcand;
  logic [31:0] partial;
  assign mcand   = (state == SQA) ? a_q : b_q;
  assign partial = mcand[i] ? ({24'b0, mcand} << i) : 32'b0;

  // next radicand pair; acc is extended so the top pair (k=8) reads bit 17 as 0
  logic [17:0] acc_ext;
  logic [4:0]  pair_lsb;
  logic [1:0]  pair;
  logic [20:0] trial;
  logic [10:0] test;
  assign acc_ext  = {1'b0, acc};
  assign pair_lsb = {k, 1'b0};
  assign pair     = acc_ext[pair_lsb +: 2];
  assign trial    = {rem, pair};
  assign test     = {root, 2'b01};

  logic unused_alu_bits;
  assign unused_alu_bits = ^bus.aluResult[31:19];

  // ALU operand mux; forced to zero whenever the core owns the ALU
  always_comb begin
    bus.aluOper = 3'b000;
    bus.aluSrcA = 32'b0;
    bus.aluSrcB = 32'b0;
    if (own_q) begin
      case (state)
        SQA, SQB: begin
          bus.aluOper = `ALU_ADD;
          bus.aluSrcA = {15'b0, acc};
          bus.aluSrcB = partial;
        end
        SQRT_CMP: begin
          bus.aluOper = `ALU_SLTU;
          bus.aluSrcA = {11'b0, trial};
          bus.aluSrcB = {21'b0, test};
        end
        SQRT_SUB: begin
          bus.aluOper = `ALU_SUB;
          bus.aluSrcA = {11'b0, trial};
          bus.aluSrcB = {21'b0, test};
        end
        default: begin
          bus.aluOper = 3'b000;
        end
      endcase
    end
  end

  assign bus.aluOwn = own_q;
  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;
  assign bus.result = (state == DONE) ? root : result_q;

  // sequencer FSM with registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      acc      <= 17'd0;
      i        <= 3'd0;
      k        <= 4'd0;
      lt       <= 1'b0;
      rem      <= 19'd0;
      root     <= 9'd0;
      result_q <= 9'd0;
      own_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q  <= bus.opA;
            b_q  <= bus.opB;
            acc  <= 17'd0;
            i    <= 3'd0;
            rem  <= 19'd0;
            root <= 9'd0;
`ifdef HYPO_ZERO_BYPASS_EN
            if (bus.opA == 8'd0 || bus.opB == 8'd0) begin
              root    <= {1'b0, bus.opA | bus.opB};
              state   <= DONE;
              own_q   <= 1'b0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              state   <= SQA;
              own_q   <= 1'b1;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end
`else
            state   <= SQA;
            own_q   <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
`endif
          end
        end
        SQA, SQB, SQRT_CMP, SQRT_SUB: begin
          if (!bus.start) begin
            state   <= IDLE;
            own_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end else begin
            case (state)
              SQA: begin
                acc <= bus.aluResult[16:0];
                i   <= i + 3'd1;
                if (i == 3'd7) state <= SQB;
              end
              SQB: begin
                acc <= bus.aluResult[16:0];
                i   <= i + 3'd1;
                if (i == 3'd7) begin
                  state <= SQRT_CMP;
                  k     <= 4'd8;
                end
              end
              SQRT_CMP: begin
                lt    <= bus.aluResult[0];
                state <= SQRT_SUB;
              end
              default: begin
                if (!lt) begin
                  rem  <= bus.aluResult[18:0];
                  root <= {root[7:0], 1'b1};
                end else begin
                  rem  <= trial[18:0];
                  root <= {root[7:0], 1'b0};
                end
                if (k == 4'd0) begin
                  state   <= DONE;
                  own_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b1;
                end else begin
                  k     <= k - 4'd1;
                  state <= SQRT_CMP;
                end
              end
            endcase
          end
        end
        DONE: begin
          result_q <= root;
          state    <= IDLE;
          own_q    <= 1'b0;
          busy_q   <= 1'b0;
          ready_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          own_q   <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
